uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter in the peripheral block between two byte requesters (req0: CPU store path, req1: hardware source such as an RX-echo or debug stream). Each requester has its own DEPTH-entry FIFO; a round-robin scheduler pops one byte at a time and issues it to the sender with a one-cycle enable pulse. It then tracks the sender's status line through start and completion before issuing the next byte. Sits between the peripheral register logic and the UART sender, on sysclk.

## Interface

- DEPTH, 4, entries per requester FIFO; power of 2, ≥2
- TIMEOUT, 255, cycles to wait for the sender to go busy after an enable pulse; ≥1
- sysclk  in  1  system clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-low; clock sysclk
- req0_valid  in  1  requester 0 offers a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  FIFO0 can accept; = (fifo0_level < DEPTH)
- req1_valid, req1_data, req1_ready: same as req0 for requester 1
- tx_status  in  1  sender idle/ready (1 = idle, 0 = shifting)
- tx_en  out  1  registered one-cycle start pulse to sender
- tx_data  out  8  registered byte to sender, held until next launch
- grant_id  out  1  requester whose byte was last launched
- busy  out  1  (state != IDLE) or either FIFO non-empty
- fifo0_level, fifo1_level  out  log2(DEPTH)+1  current occupancy
- timeout_err  out  1  sticky; set on start timeout
- err_clr  in  1  clears timeout_err

## Operation

- Push: req_valid && req_ready at a rising edge writes the byte at the tail; level +1. Valid with ready=0 is ignored. The requester holds the byte until it sees ready.
- Pop happens only at launch; the FIFOs are independent. Push and pop on the same FIFO in the same cycle leave the level unchanged, and the data order is preserved.
- Arbitration occurs in IDLE with tx_status=1.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the requester != last_grant is granted.
  - last_grant resets to 1, so req0 wins the first tie.
- FSM states are IDLE, WAIT_START and WAIT_DONE.
  - IDLE: if a FIFO is non-empty and tx_status=1, then at the edge: tx_en<=1, tx_data<=head, pop, grant_id/last_grant<=winner, cnt<=0, go to WAIT_START. Otherwise stay.
  - WAIT_START: tx_en<=0.
    - If tx_status=0, go to WAIT_DONE.
    - Else cnt+1. When cnt reaches TIMEOUT-1 with tx_status still 1, set timeout_err<=1 and go to IDLE. The byte is considered lost and is not retried.
  - WAIT_DONE: when tx_status=1, go to IDLE.
- timeout_err: err_clr clears it. If set and clear occur in the same cycle, set wins.
- Reset values (asynchronous):
  - FIFOs empty, levels 0, ready=1.
  - State IDLE, tx_en=0, tx_data=0, grant_id=0, last_grant=1, cnt=0, timeout_err=0, busy=0.
  - A reset mid-transfer drops tx_en immediately, discards all queued bytes, and does not wait for the sender.

## Timing

- Push at edge k makes a byte launchable at edge k+1. With an idle sender, tx_en is high during cycle k+1..k+2 (exactly one cycle).
- Minimum spacing between launches is 3 edges: launch, at least one WAIT_START cycle, at least one WAIT_DONE cycle, plus the IDLE re-evaluation. In practice spacing is set by the sender's frame time.
- tx_en is never high in two consecutive cycles, and never high while state != IDLE was held in the prior cycle.
- ready is combinational from the registered level, so there is no same-cycle dependence on pop.
- cnt width is ceil(log2(TIMEOUT+1)). cnt never wraps; it saturates through the timeout exit.
- Level width is log2(DEPTH)+1, so full reads DEPTH, not 0. Pointers wrap modulo DEPTH.

## Test plan

- Single byte: push 0x5A on req0 with tx_status=1. Required: tx_en one-cycle pulse with tx_data=0x5A and grant_id=0. The model drops status 2 cycles later and raises it 20 cycles later; busy falls 1 cycle after status rises.
- Round-robin: preload req0 with {0x01,0x02} and req1 with {0xA1,0xA2}. Required launch order is 0x01, 0xA1, 0x02, 0xA2, with grant_id 0,1,0,1.
- Full FIFO: push 4 bytes on req1 while tx_status is held 0. Required: fifo1_level=4 and req1_ready=0; a 5th valid is ignored; after the sender frees, exactly 4 bytes are sent in order.
- Timeout: launch with tx_status stuck at 1. Required: timeout_err=1 exactly TIMEOUT cycles after the pulse and the FSM returns to IDLE. Asserting err_clr then clears it; set and clear in the same cycle leave it 1.
- Reset mid-frame: assert reset in WAIT_DONE with 2 bytes queued. Required: tx_en=0, levels 0 and timeout_err=0 asynchronously. After release, no launch occurs until a new push.
- Concurrent push and pop: push req0 on the same edge as a req0 launch at level 2. Required: level stays 2 and the FIFO order is intact.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART sender between two byte FIFOs
module uart_tx_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     i_req0_valid,
  input  logic [7:0]               i_req0_data,
  output logic                     o_req0_ready,
  input  logic                     i_req1_valid,
  input  logic [7:0]               i_req1_data,
  output logic                     o_req1_ready,
  input  logic                     i_tx_status,
  output logic                     o_tx_en,
  output logic [7:0]               o_tx_data,
  output logic                     o_grant_id,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo0_level,
  output logic [$clog2(DEPTH):0]   o_fifo1_level,
  output logic                     o_timeout_err,
  input  logic                     i_err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [2][DEPTH];
  logic [AW-1:0] r_wp [2];
  logic [AW-1:0] r_rp [2];
  logic [LW-1:0] r_lvl [2];
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last;
  logic [1:0]    w_valid, w_ready, w_ne, w_push, w_pop;
  logic [7:0]    w_data [2];
  logic          w_winner, w_launch, w_timeout;
  assign w_valid = {i_req1_valid, i_req0_valid};
  assign w_data[0] = i_req0_data;
  assign w_data[1] = i_req1_data;
  assign w_ready = {r_lvl[1] < FULL, r_lvl[0] < FULL};
  assign w_ne = {r_lvl[1] != '0, r_lvl[0] != '0};
  assign w_push = w_valid & w_ready;
  // on a tie the requester that did not go last wins; otherwise the only non-empty one
  assign w_winner = &w_ne ? ~r_last : w_ne[1];
  assign w_pop = {w_launch & w_winner, w_launch & ~w_winner};
  assign o_req0_ready = w_ready[0];
  assign o_req1_ready = w_ready[1];
  assign o_fifo0_level = r_lvl[0];
  assign o_fifo1_level = r_lvl[1];
  assign o_busy = (r_state != IDLE) || (|w_ne);
  // next-state: launch from IDLE, watch the sender start (with timeout) and finish
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_launch = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: if ((|w_ne) && i_tx_status) begin
        w_launch = 1'b1;
        w_cnt_nxt = '0;
        w_state_nxt = WAIT_START;
      end
      WAIT_START: if (!i_tx_status) w_state_nxt = WAIT_DONE;
        else if (r_cnt == CLAST) begin
          w_timeout = 1'b1;
          w_state_nxt = IDLE;
        end
        else w_cnt_nxt = r_cnt + 1'b1;
      WAIT_DONE: if (i_tx_status) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // FSM state, registered sender outputs and the sticky timeout flag
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_tx_en <= 1'b0;
      o_tx_data <= '0;
      o_grant_id <= 1'b0;
      r_last <= 1'b1;
      o_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      o_tx_en <= w_launch;
      if (w_launch) begin
        o_tx_data <= r_mem[w_winner][r_rp[w_winner]];
        o_grant_id <= w_winner;
        r_last <= w_winner;
      end
      o_timeout_err <= w_timeout | (o_timeout_err & ~i_err_clr);
    end
  // FIFO storage needs no reset; occupancy is tracked by the pointers below
  always_ff @(posedge sysclk)
    for (int g = 0; g < 2; g++) if (w_push[g]) r_mem[g][r_wp[g]] <= w_data[g];
  // FIFO pointers and levels; simultaneous push and pop keep the level
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      r_wp <= '{default: '0};
      r_rp <= '{default: '0};
      r_lvl <= '{default: '0};
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (w_push[g]) r_wp[g] <= r_wp[g] + 1'b1;
        if (w_pop[g]) r_rp[g] <= r_rp[g] + 1'b1;
        r_lvl[g] <= r_lvl[g] + LW'(w_push[g]) - LW'(w_pop[g]);
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the two-requester UART arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int TO = 255;
  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready;
  logic tx_status = 1'b1;
  logic tx_en, grant_id, busy, timeout_err;
  logic [7:0] tx_data;
  logic [2:0] fifo0_level, fifo1_level;
  logic err_clr = 1'b0;
  logic model_en = 1'b1;
  logic prev_en = 1'b0;
  logic [8:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_launch = 0;
  int n0;
  uart_tx_arbiter #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .sysclk(sysclk), .reset(reset),
    .i_req0_valid(req0_valid), .i_req0_data(req0_data), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_data(req1_data), .o_req1_ready(req1_ready),
    .i_tx_status(tx_status), .o_tx_en(tx_en), .o_tx_data(tx_data),
    .o_grant_id(grant_id), .o_busy(busy),
    .o_fifo0_level(fifo0_level), .o_fifo1_level(fifo1_level),
    .o_timeout_err(timeout_err), .i_err_clr(err_clr)
  );
  always #5 sysclk = ~sysclk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask
  task automatic expect_b(input logic [7:0] d, input logic g);
    exp_q.push_back({g, d});
  endtask
  task automatic push(input int r, input logic [7:0] d);
    @(negedge sysclk);
    if (r == 0) begin req0_valid = 1'b1; req0_data = d; end
    else begin req1_valid = 1'b1; req1_data = d; end
    @(negedge sysclk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  task automatic push2(input logic [7:0] d0, input logic [7:0] d1);
    @(negedge sysclk);
    req0_valid = 1'b1; req0_data = d0;
    req1_valid = 1'b1; req1_data = d1;
    @(negedge sysclk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  task automatic wait_quiet(input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge sysclk); #1;
      if (!busy && tx_status) break;
    end
    total++;
    if (i == budget) begin
      bad++;
      $display("FAIL %s got=busy want=idle within %0d cycles", nm, budget);
    end
  endtask
  task automatic find_launch(input string nm);
    int i;
    for (i = 0; i < 10; i++) begin
      @(posedge sysclk); #1;
      if (tx_en) break;
    end
    total++;
    if (i == 10) begin
      bad++;
      $display("FAIL %s got=no_tx_en want=tx_en within 10 cycles", nm);
    end
  endtask
  task automatic wait_status(input logic lvl, input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge sysclk); #1;
      if (tx_status == lvl) break;
    end
    total++;
    if (i == 60) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b within 60 cycles", nm, tx_status, lvl);
    end
  endtask
  // sender model: goes busy 2 cycles after a pulse, idle again 20 cycles later
  initial forever begin
    @(posedge sysclk); #1;
    if (model_en && reset && tx_en) begin
      repeat (2) @(negedge sysclk);
      tx_status = 1'b0;
      repeat (20) @(negedge sysclk);
      tx_status = 1'b1;
    end
  end
  // monitor: every launch pops the scoreboard and must be a single-cycle pulse
  always @(posedge sysclk) begin
    #1;
    if (reset && tx_en) begin
      logic [8:0] e;
      n_launch++;
      total++;
      if (prev_en) begin
        bad++;
        $display("FAIL tx_en_pulse got=2_cycles want=1_cycle");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL launch got=%02h/g%0d want=no_launch", tx_data, grant_id);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, tx_data} !== e) begin
          bad++;
          $display("FAIL launch got=%02h/g%0d want=%02h/g%0d", tx_data, grant_id, e[7:0], e[8]);
        end
      end
    end
    prev_en = reset && tx_en;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl0", fifo0_level, 0);
    chk("rst_lvl1", fifo1_level, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);
    chk("rst_err", timeout_err, 0);
    @(negedge sysclk);
    reset = 1'b1;
    // round robin, first tie goes to req0
    tx_status = 1'b0;
    push2(8'h01, 8'hA1);
    push2(8'h02, 8'hA2);
    chk("rr_lvl0", fifo0_level, 2);
    chk("rr_lvl1", fifo1_level, 2);
    expect_b(8'h01, 0);
    expect_b(8'hA1, 1);
    expect_b(8'h02, 0);
    expect_b(8'hA2, 1);
    @(negedge sysclk);
    tx_status = 1'b1;
    wait_quiet(400, "rr_drain");
    chk("rr_sb_empty", exp_q.size(), 0);
    // single byte with busy tracking the sender
    n0 = n_launch;
    expect_b(8'h5A, 0);
    push(0, 8'h5A);
    wait_status(1'b0, "single_status_low");
    wait_status(1'b1, "single_status_high");
    chk("single_busy_before", busy, 1);
    @(posedge sysclk); #1;
    chk("single_busy_after", busy, 0);
    chk("single_count", n_launch, n0 + 1);
    // full FIFO on req1
    @(negedge sysclk);
    tx_status = 1'b0;
    push(1, 8'h11);
    push(1, 8'h22);
    push(1, 8'h33);
    push(1, 8'h44);
    chk("full_lvl1", fifo1_level, 4);
    chk("full_ready1", req1_ready, 0);
    push(1, 8'h55);
    chk("full_lvl1_after5", fifo1_level, 4);
    expect_b(8'h11, 1);
    expect_b(8'h22, 1);
    expect_b(8'h33, 1);
    expect_b(8'h44, 1);
    @(negedge sysclk);
    tx_status = 1'b1;
    wait_quiet(400, "full_drain");
    chk("full_sb_empty", exp_q.size(), 0);
    // start timeout, then clear, then set-wins-over-clear
    model_en = 1'b0;
    expect_b(8'h77, 0);
    push(0, 8'h77);
    find_launch("to1_launch");
    repeat (TO - 1) @(posedge sysclk);
    #1;
    chk("to1_err_early", timeout_err, 0);
    chk("to1_busy_early", busy, 1);
    @(posedge sysclk); #1;
    chk("to1_err", timeout_err, 1);
    chk("to1_idle", busy, 0);
    @(negedge sysclk);
    err_clr = 1'b1;
    @(posedge sysclk); #1;
    chk("to1_clr", timeout_err, 0);
    @(negedge sysclk);
    err_clr = 1'b0;
    expect_b(8'h78, 0);
    push(0, 8'h78);
    find_launch("to2_launch");
    repeat (TO - 1) @(posedge sysclk);
    @(negedge sysclk);
    err_clr = 1'b1;
    @(posedge sysclk); #1;
    chk("to2_set_wins", timeout_err, 1);
    @(negedge sysclk);
    err_clr = 1'b0;
    @(posedge sysclk); #1;
    chk("to2_sticky", timeout_err, 1);
    // asynchronous reset while waiting for the sender to finish
    expect_b(8'h31, 0);
    push(0, 8'h31);
    find_launch("rst_launch");
    @(negedge sysclk);
    tx_status = 1'b0;
    push(0, 8'h32);
    push(0, 8'h33);
    chk("mid_lvl0", fifo0_level, 2);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_tx_en", tx_en, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_lvl0_rst", fifo0_level, 0);
    chk("mid_err_rst", timeout_err, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_ready0_rst", req0_ready, 1);
    @(negedge sysclk);
    reset = 1'b1;
    tx_status = 1'b1;
    n0 = n_launch;
    repeat (10) @(posedge sysclk);
    #1;
    chk("post_rst_no_launch", n_launch, n0);
    // push on the same edge as a pop at level 2
    model_en = 1'b1;
    @(negedge sysclk);
    tx_status = 1'b0;
    push(0, 8'h41);
    push(0, 8'h42);
    chk("cc_lvl_pre", fifo0_level, 2);
    expect_b(8'h41, 0);
    expect_b(8'h42, 0);
    expect_b(8'h43, 0);
    tx_status = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h43;
    @(posedge sysclk); #1;
    chk("cc_tx_en", tx_en, 1);
    chk("cc_lvl", fifo0_level, 2);
    @(negedge sysclk);
    req0_valid = 1'b0;
    wait_quiet(400, "cc_drain");
    chk("cc_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
